// File: rtl/axis_hdr_arb_pkg.sv
// Shared definitions for the header-insert arbiter: state encoding and
// default geometry.
package axis_hdr_arb_pkg;

  localparam int DEF_DATA_WD = 32;
  localparam int DEF_NUM_SRC = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HDR     = 2'd1,
    ST_PAYLOAD = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: returns the first requester at or after
// ptr+1, wrapping modulo NUM_SRC.
module rr_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int SRC_WD  = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [SRC_WD-1:0]  ptr,
  output logic [SRC_WD-1:0]  gnt_idx,
  output logic               gnt_any
);

  logic [SRC_WD-1:0] idx;

  // Scan from the farthest candidate to the nearest so the nearest one wins.
  always_comb begin
    // NOTE: every variable written here gets a default first so no path infers a latch.
    gnt_idx = '0;
    gnt_any = 1'b0;
    idx     = '0;
    for (int k = NUM_SRC; k >= 1; k--) begin
      idx = SRC_WD'((int'(ptr) + k) % NUM_SRC);
      if (req[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = idx;
      end
    end
  end

endmodule

// File: rtl/axis_hdr_insert_arbiter.sv
// Round-robin front end that shares one header-insert datapath between
// NUM_SRC requesters: header first, then payload through last, then re-arbitrate.
module axis_hdr_insert_arbiter
  import axis_hdr_arb_pkg::*;
#(
  parameter int DATA_WD      = DEF_DATA_WD,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD),
  parameter int NUM_SRC      = DEF_NUM_SRC,
  parameter int SRC_WD       = $clog2(NUM_SRC)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_SRC-1:0]                src_valid_insert,
  input  logic [NUM_SRC*DATA_WD-1:0]        src_data_insert,
  input  logic [NUM_SRC*DATA_BYTE_WD-1:0]   src_keep_insert,
  input  logic [NUM_SRC*BYTE_CNT_WD-1:0]    src_byte_insert_cnt,
  output logic [NUM_SRC-1:0]                src_ready_insert,
  input  logic [NUM_SRC-1:0]                src_valid_in,
  input  logic [NUM_SRC*DATA_WD-1:0]        src_data_in,
  input  logic [NUM_SRC*DATA_BYTE_WD-1:0]   src_keep_in,
  input  logic [NUM_SRC-1:0]                src_last_in,
  output logic [NUM_SRC-1:0]                src_ready_in,
  output logic                              valid_insert,
  output logic [DATA_WD-1:0]                data_insert,
  output logic [DATA_BYTE_WD-1:0]           keep_insert,
  output logic [BYTE_CNT_WD-1:0]            byte_insert_cnt,
  input  logic                              ready_insert,
  output logic                              valid_in,
  output logic [DATA_WD-1:0]                data_in,
  output logic [DATA_BYTE_WD-1:0]           keep_in,
  output logic                              last_in,
  input  logic                              ready_in,
  output logic [SRC_WD-1:0]                 grant_id,
  output logic                              busy,
  output logic                              pkt_done
);

  arb_state_t        state_q, state_d;
  logic [SRC_WD-1:0] grant_q, grant_d;
  logic [SRC_WD-1:0] rr_ptr_q, rr_ptr_d;
  logic              pkt_done_q, pkt_done_d;

  logic [SRC_WD-1:0] arb_idx;
  logic              arb_any;

  // Per-source slices of the flat input buses, indexed by the grant below.
  logic [DATA_WD-1:0]      hdr_data  [NUM_SRC];
  logic [DATA_BYTE_WD-1:0] hdr_keep  [NUM_SRC];
  logic [BYTE_CNT_WD-1:0]  hdr_cnt   [NUM_SRC];
  logic [DATA_WD-1:0]      pl_data   [NUM_SRC];
  logic [DATA_BYTE_WD-1:0] pl_keep   [NUM_SRC];

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_slice
    assign hdr_data[i] = src_data_insert[i*DATA_WD +: DATA_WD];
    assign hdr_keep[i] = src_keep_insert[i*DATA_BYTE_WD +: DATA_BYTE_WD];
    assign hdr_cnt[i]  = src_byte_insert_cnt[i*BYTE_CNT_WD +: BYTE_CNT_WD];
    assign pl_data[i]  = src_data_in[i*DATA_WD +: DATA_WD];
    assign pl_keep[i]  = src_keep_in[i*DATA_BYTE_WD +: DATA_BYTE_WD];
  end

  rr_arbiter #(
    .NUM_SRC (NUM_SRC),
    .SRC_WD  (SRC_WD)
  ) u_rr_arbiter (
    .req     (src_valid_insert),
    .ptr     (rr_ptr_q),
    .gnt_idx (arb_idx),
    .gnt_any (arb_any)
  );

  logic sel_valid_insert;
  logic sel_valid_in;
  logic sel_last_in;

  assign sel_valid_insert = src_valid_insert[grant_q];
  assign sel_valid_in     = src_valid_in[grant_q];
  assign sel_last_in      = src_last_in[grant_q];

  // Data-path fields follow the grant unconditionally; only valids/readies are gated.
  assign data_insert     = hdr_data[grant_q];
  assign keep_insert     = hdr_keep[grant_q];
  assign byte_insert_cnt = hdr_cnt[grant_q];
  assign data_in         = pl_data[grant_q];
  assign keep_in         = pl_keep[grant_q];
  assign last_in         = sel_last_in;

  assign grant_id = grant_q;
  assign busy     = (state_q != ST_IDLE);
  assign pkt_done = pkt_done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      rr_ptr_q   <= SRC_WD'(NUM_SRC - 1);
      pkt_done_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      pkt_done_q <= pkt_done_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    grant_d          = grant_q;
    rr_ptr_d         = rr_ptr_q;
    pkt_done_d       = 1'b0;
    valid_insert     = 1'b0;
    valid_in         = 1'b0;
    src_ready_insert = '0;
    src_ready_in     = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          state_d = ST_HDR;
          grant_d = arb_idx;
        end
      end

      ST_HDR: begin
        valid_insert              = sel_valid_insert;
        src_ready_insert[grant_q] = ready_insert;
        if (sel_valid_insert && ready_insert) begin
          state_d = ST_PAYLOAD;
        end else if (!sel_valid_insert) begin
          // Requester withdrew its header; abandon without advancing rr_ptr.
          state_d = ST_IDLE;
        end
      end

      ST_PAYLOAD: begin
        valid_in              = sel_valid_in;
        src_ready_in[grant_q] = ready_in;
        if (sel_valid_in && ready_in && sel_last_in) begin
          state_d    = ST_IDLE;
          rr_ptr_d   = grant_q;
          pkt_done_d = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_axis_hdr_insert_arbiter.sv
// Directed and randomized checks of the header-insert arbiter against a
// transaction-level round-robin model kept in the bench.
module tb_axis_hdr_insert_arbiter;

  localparam int NS = 4;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int CW = $clog2(BW);
  localparam int SW = $clog2(NS);

  typedef struct packed {
    logic [DW-1:0] hdr;
    logic [BW-1:0] hkeep;
    logic [CW-1:0] cnt;
    logic [3:0]    nbeats;
    logic [DW-1:0] seed;
    logic [BW-1:0] lkeep;
  } pkt_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NS-1:0]     src_valid_insert = '0;
  logic [NS*DW-1:0]  src_data_insert = '0;
  logic [NS*BW-1:0]  src_keep_insert = '0;
  logic [NS*CW-1:0]  src_byte_insert_cnt = '0;
  logic [NS-1:0]     src_ready_insert;
  logic [NS-1:0]     src_valid_in = '0;
  logic [NS*DW-1:0]  src_data_in = '0;
  logic [NS*BW-1:0]  src_keep_in = '0;
  logic [NS-1:0]     src_last_in = '0;
  logic [NS-1:0]     src_ready_in;
  logic              valid_insert;
  logic [DW-1:0]     data_insert;
  logic [BW-1:0]     keep_insert;
  logic [CW-1:0]     byte_insert_cnt;
  logic              ready_insert = 1'b1;
  logic              valid_in;
  logic [DW-1:0]     data_in;
  logic [BW-1:0]     keep_in;
  logic              last_in;
  logic              ready_in = 1'b1;
  logic [SW-1:0]     grant_id;
  logic              busy;
  logic              pkt_done;

  always #5 clk = ~clk;

  axis_hdr_insert_arbiter #(
    .DATA_WD (DW),
    .NUM_SRC (NS)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .src_valid_insert    (src_valid_insert),
    .src_data_insert     (src_data_insert),
    .src_keep_insert     (src_keep_insert),
    .src_byte_insert_cnt (src_byte_insert_cnt),
    .src_ready_insert    (src_ready_insert),
    .src_valid_in        (src_valid_in),
    .src_data_in         (src_data_in),
    .src_keep_in         (src_keep_in),
    .src_last_in         (src_last_in),
    .src_ready_in        (src_ready_in),
    .valid_insert        (valid_insert),
    .data_insert         (data_insert),
    .keep_insert         (keep_insert),
    .byte_insert_cnt     (byte_insert_cnt),
    .ready_insert        (ready_insert),
    .valid_in            (valid_in),
    .data_in             (data_in),
    .keep_in             (keep_in),
    .last_in             (last_in),
    .ready_in            (ready_in),
    .grant_id            (grant_id),
    .busy                (busy),
    .pkt_done            (pkt_done)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Source-side state: pending packets and progress through the current one.
  pkt_t pq [NS][$];
  bit   in_pl    [NS];
  int   beat_idx [NS];

  // Reference model: who owns the datapath, whether its header is through,
  // who was served last, and the expected done pulse.
  int m_owner = -1;
  int m_last  = NS - 1;
  bit m_hdr   = 1'b0;
  bit m_done  = 1'b0;
  int m_glog [$];

  int            glog [$];
  bit            prev_busy = 1'b0;
  int            n_done = 0;
  int            hdr_wait = 0;
  logic [DW-1:0] obs_data [$];
  logic [BW-1:0] obs_keep [$];

  int ins_mode  = 0;  // 0: ready, 1: random, 2: low while hold_left > 0
  int rin_mode  = 0;  // 0: ready, 1: random, 2: toggle
  int hold_left = 0;
  int kill_src  = -1;
  bit pl_rand   = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [DW-1:0] beat_data(input pkt_t p, input int b);
    return p.seed ^ DW'(b * 32'h9E37_79B9);
  endfunction

  function automatic pkt_t mk_pkt(input int nb);
    pkt_t p;
    p.hdr    = $urandom;
    p.hkeep  = BW'($urandom);
    p.cnt    = CW'($urandom);
    p.nbeats = 4'(nb);
    p.seed   = $urandom;
    p.lkeep  = BW'($urandom_range(1, (1 << BW) - 1));
    return p;
  endfunction

  task automatic clear_logs();
    glog.delete();
    m_glog.delete();
    obs_data.delete();
    obs_keep.delete();
    n_done   = 0;
    hdr_wait = 0;
  endtask

  task automatic drive();
    pkt_t p;
    bit   lst;
    if (kill_src >= 0) begin
      if (!in_pl[kill_src] && pq[kill_src].size() > 0) void'(pq[kill_src].pop_front());
      kill_src = -1;
    end
    for (int i = 0; i < NS; i++) begin
      if (pq[i].size() > 0 && !in_pl[i]) begin
        p = pq[i][0];
        src_valid_insert[i]             = 1'b1;
        src_data_insert[i*DW +: DW]     = p.hdr;
        src_keep_insert[i*BW +: BW]     = p.hkeep;
        src_byte_insert_cnt[i*CW +: CW] = p.cnt;
      end else begin
        src_valid_insert[i]             = 1'b0;
        src_data_insert[i*DW +: DW]     = $urandom;
        src_keep_insert[i*BW +: BW]     = BW'($urandom);
        src_byte_insert_cnt[i*CW +: CW] = CW'($urandom);
      end
      if (in_pl[i]) begin
        p   = pq[i][0];
        lst = (beat_idx[i] == int'(p.nbeats) - 1);
        src_valid_in[i]         = pl_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        src_data_in[i*DW +: DW] = beat_data(p, beat_idx[i]);
        src_keep_in[i*BW +: BW] = lst ? p.lkeep : '1;
        src_last_in[i]          = lst;
      end else begin
        // Payload-side noise from idle sources must never be forwarded.
        src_valid_in[i]         = 1'($urandom_range(0, 1));
        src_data_in[i*DW +: DW] = $urandom;
        src_keep_in[i*BW +: BW] = BW'($urandom);
        src_last_in[i]          = 1'($urandom_range(0, 1));
      end
    end
    case (ins_mode)
      0:       ready_insert = 1'b1;
      1:       ready_insert = 1'($urandom_range(0, 1));
      default: begin
        ready_insert = (hold_left > 0) ? 1'b0 : 1'b1;
        if (hold_left > 0) hold_left--;
      end
    endcase
    case (rin_mode)
      0:       ready_in = 1'b1;
      1:       ready_in = 1'($urandom_range(0, 1));
      default: ready_in = ~ready_in;
    endcase
  endtask

  task automatic cycle();
    int            own;
    bit            hp, pp, exp_vi, exp_vn, hs_h, hs_p, lst;
    logic [NS-1:0] exp_r;
    @(negedge clk);
    own = m_owner;
    hp  = (own >= 0) && !m_hdr;
    pp  = (own >= 0) && m_hdr;

    exp_vi = hp ? src_valid_insert[own] : 1'b0;
    check("valid_insert", valid_insert, exp_vi);
    if (exp_vi) begin
      check("data_insert", data_insert, pq[own][0].hdr);
      check("keep_insert", keep_insert, pq[own][0].hkeep);
      check("byte_insert_cnt", byte_insert_cnt, pq[own][0].cnt);
    end
    exp_r = '0;
    if (hp) exp_r[own] = ready_insert;
    check("src_ready_insert", src_ready_insert, exp_r);

    exp_vn = pp ? src_valid_in[own] : 1'b0;
    check("valid_in", valid_in, exp_vn);
    if (exp_vn) begin
      check("data_in", data_in, src_data_in[own*DW +: DW]);
      check("keep_in", keep_in, src_keep_in[own*BW +: BW]);
      check("last_in", last_in, src_last_in[own]);
    end
    exp_r = '0;
    if (pp) exp_r[own] = ready_in;
    check("src_ready_in", src_ready_in, exp_r);

    check("busy", busy, own >= 0);
    if (own >= 0) check("grant_id", grant_id, own);
    check("pkt_done", pkt_done, m_done);

    if (busy && !prev_busy) glog.push_back(int'(grant_id));
    prev_busy = busy;
    if (pkt_done) n_done++;
    if (valid_in && ready_in) begin
      obs_data.push_back(data_in);
      obs_keep.push_back(keep_in);
    end
    if (valid_insert && !ready_insert) hdr_wait++;

    hs_h = hp && src_valid_insert[own] && ready_insert;
    hs_p = pp && src_valid_in[own] && ready_in;
    lst  = hs_p && src_last_in[own];

    @(posedge clk);
    #1;
    m_done = 1'b0;
    if (own < 0) begin
      for (int k = 1; k <= NS; k++) begin
        int c;
        c = (m_last + k) % NS;
        if (src_valid_insert[c]) begin
          m_owner = c;
          m_hdr   = 1'b0;
          m_glog.push_back(c);
          break;
        end
      end
    end else if (!m_hdr) begin
      if (hs_h) m_hdr = 1'b1;
      else if (!src_valid_insert[own]) m_owner = -1;
    end else if (lst) begin
      m_last  = own;
      m_owner = -1;
      m_done  = 1'b1;
    end

    if (hs_h) in_pl[own] = 1'b1;
    if (hs_p) begin
      if (lst) begin
        void'(pq[own].pop_front());
        in_pl[own]    = 1'b0;
        beat_idx[own] = 0;
      end else begin
        beat_idx[own]++;
      end
    end
    drive();
  endtask

  function automatic int pending();
    int n;
    n = (m_owner >= 0) + int'(m_done);
    for (int i = 0; i < NS; i++) n += pq[i].size();
    return n;
  endfunction

  task automatic drain(input int max_cycles);
    int c;
    c = 0;
    while (pending() > 0 && c < max_cycles) begin
      cycle();
      c++;
    end
    check("drain_bound", pending(), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < NS; i++) begin
      pq[i].delete();
      in_pl[i]    = 1'b0;
      beat_idx[i] = 0;
    end
    m_owner   = -1;
    m_last    = NS - 1;
    m_hdr     = 1'b0;
    m_done    = 1'b0;
    prev_busy = 1'b0;
    kill_src  = -1;
    hold_left = 0;
    drive();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic check_glog(input string tag, input int exp_q[$]);
    check({tag, "_len"}, glog.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < glog.size(); i++) check(tag, glog[i], exp_q[i]);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    pkt_t p1;
    int   s;
    int   w;

    // Reset values while rst_n is held low.
    drive();
    #12;
    check("rst_busy", busy, 0);
    check("rst_grant_id", grant_id, 0);
    check("rst_pkt_done", pkt_done, 0);
    check("rst_valid_insert", valid_insert, 0);
    check("rst_valid_in", valid_in, 0);
    check("rst_src_ready_in", src_ready_in, 0);
    check("rst_src_ready_insert", src_ready_insert, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single packet from source 0.
    clear_logs();
    p1        = mk_pkt(3);
    p1.hdr    = 32'hA5A5_A5A5;
    p1.cnt    = CW'(3);
    p1.hkeep  = '1;
    p1.lkeep  = 4'hE;
    pq[0].push_back(p1);
    drive();
    drain(100);
    check_glog("t1_grant", '{0});
    check("t1_pkt_done_count", n_done, 1);
    check("t1_beat_count", obs_data.size(), 3);
    for (int i = 0; i < 3 && i < obs_data.size(); i++) check("t1_beat_data", obs_data[i], beat_data(p1, i));
    if (obs_keep.size() == 3) begin
      check("t1_keep_mid", obs_keep[1], 4'hF);
      check("t1_keep_last", obs_keep[2], 4'hE);
    end
    check("t1_idle", busy, 0);

    // Sources 0 and 1 request together.
    do_reset();
    clear_logs();
    pq[0].push_back(mk_pkt(2));
    pq[1].push_back(mk_pkt(3));
    drive();
    drain(100);
    check_glog("t2_grant", '{0, 1});

    // All four request continuously, two packets each.
    do_reset();
    clear_logs();
    for (int i = 0; i < NS; i++) begin
      pq[i].push_back(mk_pkt($urandom_range(1, 4)));
      pq[i].push_back(mk_pkt($urandom_range(1, 4)));
    end
    drive();
    drain(400);
    check_glog("t3_grant", '{0, 1, 2, 3, 0, 1, 2, 3});
    check("t3_pkt_done_count", n_done, 8);

    // Header back-pressure for five cycles.
    clear_logs();
    ins_mode  = 2;
    hold_left = 6;
    pq[2].push_back(mk_pkt(2));
    drive();
    drain(100);
    check("t4_hdr_wait", hdr_wait, 5);
    check_glog("t4_grant", '{2});
    ins_mode = 0;

    // Toggling payload ready; late requesters wait their turn.
    clear_logs();
    rin_mode = 2;
    pq[1].push_back(mk_pkt(4));
    drive();
    repeat (2) cycle();
    pq[0].push_back(mk_pkt(2));
    pq[3].push_back(mk_pkt(3));
    drain(200);
    check_glog("t5_grant", '{1, 3, 0});
    rin_mode = 0;

    // Header withdrawn mid-HDR: back to IDLE, rr pointer left alone.
    clear_logs();
    ins_mode  = 2;
    hold_left = 10;
    pq[2].push_back(mk_pkt(2));
    drive();
    repeat (4) cycle();
    kill_src = 2;
    repeat (3) cycle();
    check("abort_idle", busy, 0);
    hold_left = 0;
    ins_mode  = 0;
    pq[3].push_back(mk_pkt(2));
    pq[2].push_back(mk_pkt(1));
    drain(100);
    check_glog("abort_grant", '{2, 2, 3});

    // Randomized traffic and back-pressure against the model.
    do_reset();
    clear_logs();
    ins_mode = 1;
    rin_mode = 1;
    pl_rand  = 1'b1;
    repeat (600) begin
      if ($urandom_range(0, 3) == 0) begin
        s = $urandom_range(0, NS - 1);
        if (pq[s].size() < 3) pq[s].push_back(mk_pkt($urandom_range(1, 5)));
      end
      cycle();
    end
    drain(3000);
    check("rand_grant_len", glog.size(), m_glog.size());
    for (int i = 0; i < glog.size() && i < m_glog.size(); i++) check("rand_grant", glog[i], m_glog[i]);
    ins_mode = 0;
    rin_mode = 0;
    pl_rand  = 1'b0;

    // Reset asserted in the middle of a payload.
    do_reset();
    clear_logs();
    pq[0].push_back(mk_pkt(1));
    drive();
    drain(50);
    pq[2].push_back(mk_pkt(5));
    drive();
    w = 0;
    while (!(m_owner == 2 && m_hdr) && w < 50) begin
      cycle();
      w++;
    end
    check("pre_reset_busy", busy, 1);
    check("pre_reset_valid_in", valid_in, 1);
    #3;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid_in", valid_in, 0);
    check("mid_rst_src_ready_in", src_ready_in, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_pkt_done", pkt_done, 0);
    check("mid_rst_grant_id", grant_id, 0);
    do_reset();
    clear_logs();
    pq[1].push_back(mk_pkt(2));
    pq[0].push_back(mk_pkt(2));
    drive();
    drain(100);
    check_glog("post_rst_grant", '{0, 1});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/axis_hdr_insert_arbiter.md
Name: axis_hdr_insert_arbiter

Overview:
- Shares one axi_stream_insert_header datapath between NUM_SRC requesters.
- Each requester presents a header channel and a payload channel. The arbiter grants one requester round-robin and routes that requester's header, then its payload through the last beat, into the inserter. It then re-arbitrates.
- Sits directly upstream of the inserter's insert and in ports; the inserter's out port is untouched.

Parameters:
- DATA_WD, 32, payload and header beat width in bits.
- DATA_BYTE_WD, DATA_WD/8, keep width.
- BYTE_CNT_WD, $clog2(DATA_BYTE_WD), byte_insert_cnt width.
- NUM_SRC, 4, number of requesters (2..8).
- SRC_WD, $clog2(NUM_SRC), grant index width.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous, active-low reset.
- src_valid_insert  in  NUM_SRC  per-source header valid.
- src_data_insert  in  NUM_SRC*DATA_WD  per-source header data; source i occupies slice i.
- src_keep_insert  in  NUM_SRC*DATA_BYTE_WD  per-source header keep.
- src_byte_insert_cnt  in  NUM_SRC*BYTE_CNT_WD  per-source header byte count.
- src_ready_insert  out  NUM_SRC  per-source header ready.
- src_valid_in  in  NUM_SRC  per-source payload valid.
- src_data_in  in  NUM_SRC*DATA_WD  per-source payload data.
- src_keep_in  in  NUM_SRC*DATA_BYTE_WD  per-source payload keep.
- src_last_in  in  NUM_SRC  per-source payload last.
- src_ready_in  out  NUM_SRC  per-source payload ready.
- valid_insert, data_insert, keep_insert, byte_insert_cnt  out  1/DATA_WD/DATA_BYTE_WD/BYTE_CNT_WD  header channel to the inserter.
- ready_insert  in  1  header ready from the inserter.
- valid_in, data_in, keep_in, last_in  out  1/DATA_WD/DATA_BYTE_WD/1  payload channel to the inserter.
- ready_in  in  1  payload ready from the inserter.
- grant_id  out  SRC_WD  currently or last granted source.
- busy  out  1  high in HDR or PAYLOAD.
- pkt_done  out  1  one-cycle pulse on the granted source's last payload handshake.

Behaviour:
- States: IDLE, HDR, PAYLOAD. Held in state and grant registers; all other outputs are combinational decodes of those registers plus inputs.
- Reset (async, immediate): state=IDLE, grant_id=0, rr_ptr=NUM_SRC-1 so source 0 has top priority, pkt_done=0. All valid/ready outputs are 0 because they are gated by state.
- IDLE:
  - Outputs valid_insert=valid_in=0; all src_ready_*=0.
  - If any src_valid_insert is high, pick the first requester at or after rr_ptr+1 (mod NUM_SRC), register it as grant_id, and go to HDR.
  - Latency: request seen at edge N, header valid to inserter in cycle N+1.
  - Payload valids do not request service.
- HDR:
  - Header channel of source g=grant_id is muxed out: valid_insert=src_valid_insert[g]; src_ready_insert[g]=ready_insert; other readies are 0.
  - Payload channel is gated: valid_in=0, src_ready_in=0.
  - Handshake (valid_insert & ready_insert) -> PAYLOAD.
  - If src_valid_insert[g] drops before the handshake (protocol violation), return to IDLE; rr_ptr is unchanged.
- PAYLOAD:
  - Payload of g is muxed out: valid_in=src_valid_in[g]; src_ready_in[g]=ready_in.
  - Header channel is gated: valid_insert=0, all src_ready_insert=0.
  - Beats with ready_in=0 hold the state; no timeout.
  - On handshake with src_last_in[g]=1: pkt_done=1 next cycle, rr_ptr<=g, state -> IDLE. This costs one idle bubble before the next grant.
- Muxed data, keep and cnt outputs follow grant_id even when their valid is 0; their value is don't-care.
- Simultaneous requests resolve strictly round-robin. A new request arriving during HDR or PAYLOAD waits; grant is never pre-empted.
- A source's header valid asserted in the same cycle its previous last beat completes is served only after round-robin ordering in IDLE.
- Reset mid-packet: everything returns to reset values immediately. No flush is generated; the downstream reset is expected to occur together with this one.
- Ungranted sources always see ready=0.

Decomposition:
- Package axis_hdr_arb_pkg: state encoding (IDLE=2'd0, HDR=2'd1, PAYLOAD=2'd2), default DATA_WD and NUM_SRC constants.
- Sub-module rr_arbiter: combinational; inputs req[NUM_SRC] and ptr[SRC_WD]; outputs gnt_idx and gnt_any. Top level holds the FSM, rr_ptr, muxes and gating.

Test Plan:
- Single source 0: header 0xA5A5A5A5, cnt=3, then 3 payload beats with the last keep=4'hE. Required: valid_insert in the cycle after the request; 3 beats forwarded in order; pkt_done pulses once; state back to IDLE.
- Sources 0 and 1 request in the same cycle. Required: src0 served fully, one IDLE bubble, then src1; grant_id sequence 0,1.
- All 4 request continuously, 2 packets each. Required: grant order 0,1,2,3,0,1,2,3.
- ready_insert held low 5 cycles in HDR. Required: valid_insert and data_insert stable; src_ready_insert[g]=0; no transition until ready_insert=1.
- ready_in toggles on the last beat. Required: grant is held until the last handshake; src_ready_in stays 0 for the other sources.
- rst_n low during PAYLOAD. Required: valid_in, src_ready_in, busy and pkt_done drop in the same cycle; the first grant after reset goes to source 0.
